// File: rtl/spc_event_reporter.sv
// spc_event_reporter: queues debug event records and writes them, plus SPC status words,
// into a circular SPC cache window over a DWR/DACK handshake. Option macro: SPC_TIMESTAMP_EN.
module spc_event_reporter #(
    parameter int DW        = 32,
    parameter int NEV       = 8,
    parameter int DEPTH     = 4,
    parameter int BASE_ADDR = 80,
    parameter int ADDR_SPAN = 16
) (
    input  logic                   clk,
    input  logic                   MASRSTN,
    input  logic [NEV-1:0]         ev,
    input  logic [DW-1:0]          ev_data,
    input  logic                   cert,
    input  logic                   SPCDIS,
    input  logic                   SPCREQ,
    input  logic                   DACK,
    output logic                   DWR,
    output logic [31:0]            DAD,
    output logic [DW-1:0]          DO,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] fifo_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef SPC_TIMESTAMP_EN
    localparam int PW = DW - NEV - 24;
`else
    localparam int PW = DW - NEV - 8;
`endif
    localparam logic [31:0] BASE      = 32'(BASE_ADDR);
    localparam logic [31:0] SPAN_MASK = 32'(ADDR_SPAN - 1);

    typedef enum logic [1:0] {IDLE, WRITE, STATUS} state_t;

    state_t          r_state, w_state_next;
    logic            r_dwr, w_dwr_next;
    logic [31:0]     r_dad, w_dad_next;
    logic [DW-1:0]   r_do, w_do_next;
    logic            r_ovf;
    logic            r_pend, w_pend_next;
    logic [7:0]      r_seq;
    logic [7:0]      r_drop, w_drop_next;
    logic [CW-1:0]   r_cnt, w_cnt_next, w_cnt_after_pop;
    logic [AW-1:0]   r_wptr, r_rptr, w_rd_idx;
    logic [DW-1:0]   r_mem [DEPTH];
    logic            w_full, w_push_req, w_pop, w_push, w_drop, w_adv;
    logic [DW-1:0]   w_record, w_head, w_status;
    logic            w_unused_ev_data;

    assign w_full          = (r_cnt == CW'(DEPTH));
    assign w_push_req      = SPCDIS && (ev != '0);
    assign w_pop           = SPCDIS && (r_state == WRITE) && DACK;
    assign w_adv           = SPCDIS && (r_state != IDLE) && DACK;
    assign w_push          = w_push_req && (!w_full || w_pop);
    assign w_drop          = w_push_req && !w_push;
    assign w_cnt_after_pop = r_cnt - CW'(w_pop);
    assign w_cnt_next      = w_cnt_after_pop + CW'(w_push);
    assign w_drop_next     = (w_drop && (r_drop != 8'hFF)) ? r_drop + 8'd1 : r_drop;
    assign w_dad_next      = BASE + ((r_dad - BASE + 32'd1) & SPAN_MASK);
    assign w_unused_ev_data = &{1'b0, ev_data[DW-1:PW]};

    // An empty FIFO forwards the incoming record so a new event is written the next cycle
    assign w_rd_idx = r_rptr + AW'(w_pop);
    assign w_head   = (w_cnt_after_pop != '0) ? r_mem[w_rd_idx] : w_record;
    assign w_status = {w_drop_next, 8'(w_cnt_next), {(DW-20){1'b0}}, 4'hE};

`ifdef SPC_TIMESTAMP_EN
    logic [15:0] r_ts;
    always_ff @(posedge clk or negedge MASRSTN) begin
        if (!MASRSTN) r_ts <= '0;
        else          r_ts <= r_ts + 16'd1;
    end
    assign w_record = {r_ts, ev_data[PW-1:0], r_seq, ev};
`else
    assign w_record = {ev_data[PW-1:0], r_seq, ev};
`endif

    always_comb begin
        w_state_next = r_state;
        w_dwr_next   = r_dwr;
        w_do_next    = r_do;
        w_pend_next  = r_pend;
        if (!SPCDIS) begin
            w_state_next = IDLE;
            w_dwr_next   = 1'b0;
            w_pend_next  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (SPCREQ || r_pend) begin
                        w_state_next = STATUS;
                        w_dwr_next   = 1'b1;
                        w_do_next    = w_status;
                    end else if ((w_cnt_next != '0) && cert) begin
                        w_state_next = WRITE;
                        w_dwr_next   = 1'b1;
                        w_do_next    = w_head;
                    end
                end
                WRITE: begin
                    if (DACK) begin
                        if (SPCREQ || r_pend) begin
                            w_state_next = STATUS;
                            w_do_next    = w_status;
                        end else if ((w_cnt_next != '0) && cert) begin
                            w_do_next    = w_head;
                        end else begin
                            w_state_next = IDLE;
                            w_dwr_next   = 1'b0;
                        end
                    end else if (SPCREQ) begin
                        w_pend_next = 1'b1;
                    end
                end
                STATUS: begin
                    if (DACK) begin
                        w_state_next = IDLE;
                        w_dwr_next   = 1'b0;
                        w_pend_next  = 1'b0;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_dwr_next   = 1'b0;
                end
            endcase
        end
    end

    // Disabling the IP flushes the queue but keeps address, sequence and drop history
    always_ff @(posedge clk or negedge MASRSTN) begin
        if (!MASRSTN) begin
            r_state <= IDLE;
            r_dwr   <= 1'b0;
            r_dad   <= BASE;
            r_do    <= '0;
            r_ovf   <= 1'b0;
            r_pend  <= 1'b0;
            r_seq   <= '0;
            r_drop  <= '0;
            r_cnt   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_dwr   <= w_dwr_next;
            r_do    <= w_do_next;
            r_pend  <= w_pend_next;
            r_drop  <= w_drop_next;
            if (w_drop) r_ovf <= 1'b1;
            if (w_push) r_seq <= r_seq + 8'd1;
            if (w_adv)  r_dad <= w_dad_next;
            if (!SPCDIS) begin
                r_cnt  <= '0;
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                r_cnt <= w_cnt_next;
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= w_rd_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_record;
    end

    assign DWR      = r_dwr;
    assign DAD      = r_dad;
    assign DO       = r_do;
    assign ovf      = r_ovf;
    assign fifo_cnt = r_cnt;
endmodule
